// File: rtl/apuf_response_sampler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apuf_pkg
//  Purpose  : Shared types and constants for the arbiter PUF response
//             sampler: FSM state encoding, default sizing constants and
//             the majority-vote threshold function.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package apuf_pkg;

  localparam int DEF_CHAL_W     = 64;
  localparam int DEF_N_EVAL     = 7;
  localparam int DEF_SETTLE_CYC = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    SAMPLE = 3'd2,
    RELAX  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Strict majority over n evaluations (n is odd, so no ties exist).
  function automatic logic majority_vote(input int ones, input int n);
    return (ones > (n / 2));
  endfunction

endpackage
`default_nettype wire

// File: rtl/apuf_response_sampler_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Generic two-flop synchronizer for a single asynchronous bit.
//  Ports    : clk  - destination clock
//             rst  - synchronous active-high reset, clears both flops
//             d    - asynchronous input
//             q    - synchronized output (stage 2)
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // First stage may go metastable; only the second stage is consumed.
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apuf_response_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : apuf_response_sampler
//  Purpose  : Response side of an arbiter PUF. Accepts a challenge, drives it
//             onto the switch-stage selects, repeats launch/sample/relax
//             N_EVAL times and returns the majority-voted response bit.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             chal_valid/chal_ready/chal_data - challenge handshake
//             apuf_chal, apuf_launch          - drive into the delay chain
//             apuf_resp                       - raw arbiter output (async)
//             resp_valid/resp_ready           - response handshake
//             resp_bit, resp_ones             - voted bit, count of ones
//             busy                            - not in IDLE
//             resp_unstable, unstable_seen    - only with
//                                               APUF_STABILITY_FLAG_EN
//  Options  : APUF_STABILITY_FLAG_EN adds the vote-stability outputs.
//  Revision : 1.0  initial release
// ============================================================================
module apuf_response_sampler
  import apuf_pkg::*;
#(
  parameter  int CHAL_W     = DEF_CHAL_W,
  parameter  int N_EVAL     = DEF_N_EVAL,
  parameter  int SETTLE_CYC = DEF_SETTLE_CYC,
  localparam int CNT_W      = $clog2(N_EVAL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [CHAL_W-1:0] chal_data,
  output logic [CHAL_W-1:0] apuf_chal,
  output logic              apuf_launch,
  input  logic              apuf_resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic [CNT_W-1:0]  resp_ones,
`ifdef APUF_STABILITY_FLAG_EN
  output logic              resp_unstable,
  output logic              unstable_seen,
`endif
  output logic              busy
);

  localparam int SET_W = $clog2(SETTLE_CYC);

  generate
    if ((N_EVAL < 1) || ((N_EVAL % 2) == 0)) begin : g_chk_n_eval
      $error("apuf_response_sampler: N_EVAL must be odd and >= 1");
    end
    if (SETTLE_CYC < 3) begin : g_chk_settle
      $error("apuf_response_sampler: SETTLE_CYC must be >= 3");
    end
  endgenerate

  state_t             state;
  state_t             next_state;
  logic [SET_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   eval_cnt;
  logic [CNT_W-1:0]   ones_cnt;
  logic               resp_sync;
  logic               accept;
  logic               settle_done;
  logic               eval_done;

  sync_2ff u_resp_sync (
    .clk (clk),
    .rst (rst),
    .d   (apuf_resp),
    .q   (resp_sync)
  );

  assign accept      = chal_valid && (state == IDLE);
  assign settle_done = (settle_cnt == SET_W'(SETTLE_CYC - 1));
  assign eval_done   = (eval_cnt == CNT_W'(N_EVAL - 1));

  always_comb begin
    next_state = state;
    chal_ready = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        chal_ready = 1'b1;
        busy       = 1'b0;
        if (chal_valid) next_state = LAUNCH;
      end
      LAUNCH: if (settle_done) next_state = SAMPLE;
      SAMPLE: next_state = RELAX;
      RELAX:  if (settle_done) next_state = eval_done ? DONE : LAUNCH;
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      apuf_chal   <= '0;
      apuf_launch <= 1'b0;
      settle_cnt  <= '0;
      eval_cnt    <= '0;
      ones_cnt    <= '0;
    end else begin
      state       <= next_state;
      // Registered from the next state so the delay-chain edge is glitch-free
      // and rises in the first LAUNCH cycle.
      apuf_launch <= (next_state == LAUNCH) || (next_state == SAMPLE);
      case (state)
        IDLE: begin
          if (accept) begin
            apuf_chal  <= chal_data;
            settle_cnt <= '0;
            eval_cnt   <= '0;
            ones_cnt   <= '0;
          end
        end
        LAUNCH: settle_cnt <= settle_done ? '0 : settle_cnt + SET_W'(1);
        SAMPLE: ones_cnt   <= ones_cnt + CNT_W'(resp_sync);
        RELAX: begin
          settle_cnt <= settle_done ? '0 : settle_cnt + SET_W'(1);
          if (settle_done) eval_cnt <= eval_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ones_cnt is frozen from DONE until the next accept, so these are stable
  // for as long as resp_valid is held.
  assign resp_ones = ones_cnt;
  assign resp_bit  = majority_vote(int'(ones_cnt), N_EVAL);

`ifdef APUF_STABILITY_FLAG_EN
  assign resp_unstable = (ones_cnt != '0) && (ones_cnt != CNT_W'(N_EVAL));

  always_ff @(posedge clk) begin
    if (rst) begin
      unstable_seen <= 1'b0;
    end else if ((state == DONE) && resp_unstable) begin
      unstable_seen <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_apuf_response_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apuf_response_sampler
//  Purpose  : Self-checking bench for apuf_response_sampler with
//             N_EVAL=3, SETTLE_CYC=4 (9-cycle evaluation period).
//  Revision : 1.0  initial release
// ============================================================================
module tb_apuf_response_sampler;

  localparam int CHAL_W     = 64;
  localparam int N_EVAL     = 3;
  localparam int SETTLE_CYC = 4;
  localparam int PER        = 2 * SETTLE_CYC + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              chal_valid;
  logic              chal_ready;
  logic [CHAL_W-1:0] chal_data;
  logic [CHAL_W-1:0] apuf_chal;
  logic              apuf_launch;
  logic              apuf_resp;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_bit;
  logic [1:0]        resp_ones;
  logic              busy;
`ifdef APUF_STABILITY_FLAG_EN
  logic              resp_unstable;
  logic              unstable_seen;
`endif

  apuf_response_sampler #(
    .CHAL_W     (CHAL_W),
    .N_EVAL     (N_EVAL),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .chal_valid    (chal_valid),
    .chal_ready    (chal_ready),
    .chal_data     (chal_data),
    .apuf_chal     (apuf_chal),
    .apuf_launch   (apuf_launch),
    .apuf_resp     (apuf_resp),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_bit      (resp_bit),
    .resp_ones     (resp_ones),
`ifdef APUF_STABILITY_FLAG_EN
    .resp_unstable (resp_unstable),
    .unstable_seen (unstable_seen),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int valid_cyc;
  int launch_cyc;
  logic exp_seen;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  pat;     // pat[k] = arbiter level during evaluation k
    logic        glitch;  // base 0 with 1-cycle pulses away from SAMPLE
    int          hold;    // cycles resp_ready is held low after resp_valid
    logic        e_bit;
    logic [1:0]  e_ones;
    logic        e_uns;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input vec_t v);
    chk("resp_valid", resp_valid, 1'b1);
    chk("resp_bit", resp_bit, v.e_bit);
    chk("resp_ones", resp_ones, v.e_ones);
`ifdef APUF_STABILITY_FLAG_EN
    chk("resp_unstable", resp_unstable, v.e_uns);
    chk("unstable_seen", unstable_seen, exp_seen);
`endif
  endtask

  task automatic run_vec(input vec_t v);
    int w = 0;
    resp_ready = (v.hold == 0);
    while (!chal_ready && w < 50) begin
      tick();
      w++;
    end
    chk("chal_ready_idle", chal_ready, 1'b1);
    chal_valid = 1'b1;
    chal_data  = v.data;
    apuf_resp  = v.glitch ? 1'b0 : v.pat[0];
    tick();
    chal_valid = 1'b0;
    chal_data  = ~v.data;
    launch_cyc = cyc;
    chk("apuf_chal", apuf_chal, v.data);
    for (int k = 0; k < N_EVAL; k++) begin
      for (int j = 0; j < PER; j++) begin
        if (v.glitch) apuf_resp = (j == 1) || (j == 6);
        else          apuf_resp = v.pat[k];
        chk("apuf_launch", apuf_launch, (j <= SETTLE_CYC));
        chk("busy", busy, 1'b1);
        chk("resp_valid_early", resp_valid, 1'b0);
        tick();
      end
    end
    apuf_resp = 1'b0;
    exp_seen  = exp_seen | v.e_uns;
    valid_cyc = cyc;
    chk_resp(v);
    if (v.hold > 0) begin
      chal_valid = 1'b1;
      chal_data  = 64'hDEAD_BEEF_0BAD_F00D;
      for (int h = 0; h < v.hold; h++) begin
        tick();
        chk_resp(v);
        chk("chal_ready_hold", chal_ready, 1'b0);
        chk("launch_hold", apuf_launch, 1'b0);
      end
      chal_valid = 1'b0;
      resp_ready = 1'b1;
    end
    tick();
    chk("resp_valid_drop", resp_valid, 1'b0);
    chk("chal_ready_after", chal_ready, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("apuf_chal_held", apuf_chal, v.data);
  endtask

  initial begin
    int v0;
    int seen_valid;
    vecs[0] = '{64'hA5A5_0000_FFFF_1234, 3'b111, 1'b0, 0,  1'b1, 2'd3, 1'b0};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 3'b001, 1'b0, 10, 1'b0, 2'd1, 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 1'b0, 3,  1'b1, 2'd2, 1'b1};
    vecs[3] = '{64'h0000_0000_0000_0001, 3'b000, 1'b0, 0,  1'b0, 2'd0, 1'b0};
    vecs[4] = '{64'h5555_AAAA_5555_AAAA, 3'b000, 1'b1, 0,  1'b0, 2'd0, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 3'b110, 1'b0, 1,  1'b1, 2'd2, 1'b1};

    rst        = 1'b1;
    chal_valid = 1'b0;
    chal_data  = '0;
    apuf_resp  = 1'b0;
    resp_ready = 1'b0;
    exp_seen   = 1'b0;
    repeat (3) tick();
    chk("rst_chal_ready", chal_ready, 1'b1);
    chk("rst_apuf_chal", apuf_chal, 64'd0);
    chk("rst_launch", apuf_launch, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_bit", resp_bit, 1'b0);
    chk("rst_resp_ones", resp_ones, 2'd0);
    chk("rst_busy", busy, 1'b0);
`ifdef APUF_STABILITY_FLAG_EN
    chk("rst_resp_unstable", resp_unstable, 1'b0);
    chk("rst_unstable_seen", unstable_seen, 1'b0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back with resp_ready tied high: launch 2 cycles after resp_valid.
    run_vec(vecs[0]);
    v0 = valid_cyc;
    run_vec(vecs[3]);
    chk("b2b_launch_gap", launch_cyc - v0, 2);

    // Reset during the second RELAX discards the partial vote.
    resp_ready = 1'b1;
    chal_valid = 1'b1;
    chal_data  = 64'hCAFE_F00D_1234_5678;
    apuf_resp  = 1'b1;
    tick();
    chal_valid = 1'b0;
    repeat (PER + SETTLE_CYC + 2) tick();
    chk("mid_busy", busy, 1'b1);
    chk("mid_launch_relax", apuf_launch, 1'b0);
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    exp_seen = 1'b0;
    chk("mid_rst_launch", apuf_launch, 1'b0);
    chk("mid_rst_chal", apuf_chal, 64'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_chal_ready", chal_ready, 1'b1);
    chk("mid_rst_resp_ones", resp_ones, 2'd0);
`ifdef APUF_STABILITY_FLAG_EN
    chk("mid_rst_unstable_seen", unstable_seen, 1'b0);
`endif
    apuf_resp  = 1'b0;
    seen_valid = 0;
    repeat (40) begin
      tick();
      if (resp_valid) seen_valid++;
    end
    chk("no_resp_after_rst", seen_valid, 0);
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
